// File: rtl/regfile_bank_pkg.sv
// Shared definitions for the register bank: address-width helper and
// clear-engine state encoding.
package regfile_bank_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Ceiling log2, usable in constant expressions. Returns 1 for n <= 2.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_bank_if.sv
// Bus bundle between the datapath (master) and the register bank (slave).
interface regfile_bank_if #(
  parameter int WIDTH   = 16,
  parameter int BITSIZE = 16
);
  import regfile_bank_pkg::*;

  localparam int AW = clog2(WIDTH);

  // Handshake: a write is a single-cycle qualifier on we with no ready; the
  // bank silently drops writes while busy is high, so the master must hold
  // off until busy is low. clr_req is likewise a one-cycle pulse, ignored while busy.
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [BITSIZE-1:0]       wdata;
  logic [AW-1:0]            raddr_a;
  logic [AW-1:0]            raddr_b;
  logic [BITSIZE-1:0]       rdata_a;
  logic [BITSIZE-1:0]       rdata_b;
  logic                     clr_req;
  logic                     busy;
  logic [BITSIZE*WIDTH-1:0] regs_flat;
  logic [0:0]               state;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, clr_req,
    input  rdata_a, rdata_b, busy, regs_flat, state
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, clr_req,
    output rdata_a, rdata_b, busy, regs_flat, state
  );

endinterface

// File: rtl/regfile_bank_read_port.sv
// One combinational read port: range check, register-0 masking and
// write-through bypass of an accepted same-cycle write.
module regfile_read_port
  import regfile_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int BITSIZE  = 16,
  parameter int ZERO_REG = 1,
  parameter int AW       = clog2(WIDTH)
) (
  input  logic [AW-1:0]            raddr,
  input  logic [BITSIZE*WIDTH-1:0] regs_flat,
  input  logic                     wr_ok,
  input  logic [AW-1:0]            waddr,
  input  logic [BITSIZE-1:0]       wdata,
  output logic [BITSIZE-1:0]       rdata
);

  logic               in_range;
  logic               zero_hit;
  logic               bypass;
  logic [BITSIZE-1:0] stored;

  assign in_range = int'(raddr) < WIDTH;
  assign zero_hit = (ZERO_REG != 0) && (raddr == '0);
  // wr_ok already excludes dropped writes, so a match here is always real.
  assign bypass   = wr_ok && (waddr == raddr);

  always_comb begin
    stored = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(raddr) == i) stored = regs_flat[i*BITSIZE +: BITSIZE];
    end
  end

  always_comb begin
    rdata = '0;
    if (bypass) begin
      rdata = wdata;
    end else if (in_range && !zero_hit) begin
      rdata = stored;
    end
  end

endmodule

// File: rtl/regfile_bank.sv
// General-purpose register bank: one write port, two bypassing read ports,
// flattened contents bus and a one-register-per-cycle clear sweep.
module regfile_bank
  import regfile_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int BITSIZE  = 16,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_bank_if.slave  bus
);

  localparam int AW = clog2(WIDTH);

  logic [0:0]               state_q, state_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic [BITSIZE-1:0]       regs_q [WIDTH];
  logic [BITSIZE-1:0]       regs_d [WIDTH];
  logic [BITSIZE*WIDTH-1:0] flat;
  logic                     idle;
  logic                     wr_ok;

  assign idle  = (state_q == ST_IDLE);
  assign wr_ok = idle && bus.we && (int'(bus.waddr) < WIDTH)
                 && !((ZERO_REG != 0) && (bus.waddr == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == AW'(WIDTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
    endcase
  end

  // A write and a sweep step never coincide: writes need IDLE, sweeps need CLEAR.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && (int'(bus.waddr) == i)) regs_d[i] = bus.wdata;
      if (!idle && (int'(cnt_q) == i))     regs_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < WIDTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < WIDTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < WIDTH; i++) flat[i*BITSIZE +: BITSIZE] = regs_q[i];
  end

  assign bus.regs_flat = flat;
  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.state     = state_q;

  regfile_read_port #(
    .WIDTH(WIDTH), .BITSIZE(BITSIZE), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_rd_a (
    .raddr(bus.raddr_a), .regs_flat(flat), .wr_ok(wr_ok),
    .waddr(bus.waddr), .wdata(bus.wdata), .rdata(bus.rdata_a)
  );

  regfile_read_port #(
    .WIDTH(WIDTH), .BITSIZE(BITSIZE), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_rd_b (
    .raddr(bus.raddr_b), .regs_flat(flat), .wr_ok(wr_ok),
    .waddr(bus.waddr), .wdata(bus.wdata), .rdata(bus.rdata_b)
  );

endmodule
